// File: rtl/window_latency_monitor.sv
// Purpose : measures clk cycles between a wrap counter's 0 sample (start) and its
//           all-ones sample (end); flags windows whose latency is >= LIMIT.
// Latency : lat_o/lat_vld_o/viol_o/err_sticky_o update on the edge that samples the end.
// Backpressure: none. Samples are observed only; there is no ready/credit path.
//
// Ports   : clk, rst_n (async active-low); count_i/count_vld_i sampled counter;
//           disable_i aborts and suppresses measurement; clear_i clears err_sticky_o;
//           lat_o/lat_vld_o last latency + update pulse; viol_o violation pulse;
//           err_sticky_o sticky violation flag; viol_cnt_o saturating violation count.
// Config  : define WINDOW_LATENCY_MONITOR_VIOL_CNT_EN to build the violation counter;
//           without it viol_cnt_o is tied to 0.
module window_latency_monitor #(
    parameter int CNT_W = 3,
    parameter int TS_W  = 16,
    parameter int LIMIT = 50
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] count_i,
    input  logic             count_vld_i,
    input  logic             disable_i,
    input  logic             clear_i,
    output logic [TS_W-1:0]  lat_o,
    output logic             lat_vld_o,
    output logic             viol_o,
    output logic             err_sticky_o,
    output logic [7:0]       viol_cnt_o
);

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_ARMED = 1'b1;

    logic             state_q,   state_d;
    logic [TS_W-1:0]  timer_q,   timer_d;
    logic [TS_W-1:0]  lat_q,     lat_d;
    logic             lat_vld_q, lat_vld_d;
    logic             viol_q,    viol_d;
    logic             sticky_q,  sticky_d;

    logic start_smp;
    logic end_smp;
    logic lim_hit;

    assign start_smp = count_vld_i && (count_i == '0);
    assign end_smp   = count_vld_i && (count_i == '1);
    // Compare at 32 bits so a LIMIT larger than the timer range never truncates.
    assign lim_hit   = (32'(timer_q) >= 32'(LIMIT));

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        lat_d     = lat_q;
        lat_vld_d = 1'b0;
        viol_d    = 1'b0;

        if (disable_i) begin
            // Disable outranks any same-cycle start or end sample.
            state_d = ST_IDLE;
            timer_d = '0;
        end else if (start_smp) begin
            // A start while already armed simply restarts the window.
            state_d = ST_ARMED;
            timer_d = {{(TS_W-1){1'b0}}, 1'b1};
        end else if (state_q == ST_ARMED) begin
            if (end_smp) begin
                state_d   = ST_IDLE;
                timer_d   = '0;
                lat_d     = timer_q;
                lat_vld_d = 1'b1;
                viol_d    = lim_hit;
            end else if (timer_q != '1) begin
                timer_d = timer_q + 1'b1;
            end
        end

        // A violation in the same cycle as clear_i keeps the flag set.
        if (viol_d) begin
            sticky_d = 1'b1;
        end else if (clear_i) begin
            sticky_d = 1'b0;
        end else begin
            sticky_d = sticky_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            lat_q     <= '0;
            lat_vld_q <= 1'b0;
            viol_q    <= 1'b0;
            sticky_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            lat_q     <= lat_d;
            lat_vld_q <= lat_vld_d;
            viol_q    <= viol_d;
            sticky_q  <= sticky_d;
        end
    end

`ifdef WINDOW_LATENCY_MONITOR_VIOL_CNT_EN
    logic [7:0] viol_cnt_q, viol_cnt_d;

    // Saturates at 255; clear_i deliberately leaves the count alone.
    always_comb begin
        viol_cnt_d = viol_cnt_q;
        if (viol_d && (viol_cnt_q != 8'hFF)) begin
            viol_cnt_d = viol_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            viol_cnt_q <= 8'd0;
        end else begin
            viol_cnt_q <= viol_cnt_d;
        end
    end

    assign viol_cnt_o = viol_cnt_q;
`else
    assign viol_cnt_o = 8'd0;
`endif

    assign lat_o        = lat_q;
    assign lat_vld_o    = lat_vld_q;
    assign viol_o       = viol_q;
    assign err_sticky_o = sticky_q;

endmodule

// File: tb/tb_window_latency_monitor.sv
// Purpose : drives two monitors (TS_W=16 and TS_W=6) with identical stimulus and
//           checks them against a timestamp-based model of window latency.
// Latency/backpressure: outputs compared 1 time unit after each rising edge.
module tb_window_latency_monitor;

    localparam int CNT_W = 3;
    localparam int LIMIT = 50;
    localparam int CMAX  = 7;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] count_i;
    logic       count_vld_i;
    logic       disable_i;
    logic       clear_i;

    logic [15:0] lat_a;
    logic        lat_vld_a, viol_a, sticky_a;
    logic [7:0]  cnt_a;
    logic [5:0]  lat_b;
    logic        lat_vld_b, viol_b, sticky_b;
    logic [7:0]  cnt_b;

    always #5 clk = ~clk;

    window_latency_monitor #(.CNT_W(CNT_W), .TS_W(16), .LIMIT(LIMIT)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .count_i(count_i), .count_vld_i(count_vld_i),
        .disable_i(disable_i), .clear_i(clear_i), .lat_o(lat_a), .lat_vld_o(lat_vld_a),
        .viol_o(viol_a), .err_sticky_o(sticky_a), .viol_cnt_o(cnt_a)
    );

    window_latency_monitor #(.CNT_W(CNT_W), .TS_W(6), .LIMIT(LIMIT)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .count_i(count_i), .count_vld_i(count_vld_i),
        .disable_i(disable_i), .clear_i(clear_i), .lat_o(lat_b), .lat_vld_o(lat_vld_b),
        .viol_o(viol_b), .err_sticky_o(sticky_b), .viol_cnt_o(cnt_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model: a window is a pair of timestamps; latency = end step - start step,
    // clipped to the timer range of each instance.
    int cyc = 0;
    bit m_armed = 0;
    int m_st = 0;
    int m_max[2] = '{65535, 63};
    int m_lat[2] = '{0, 0};
    int m_vld[2] = '{0, 0};
    int m_viol[2] = '{0, 0};
    int m_sticky[2] = '{0, 0};
    int m_cnt[2] = '{0, 0};

    task automatic model(input bit rst, input bit vld, input int cnt, input bit dis, input bit clr);
        bit s, e;
        s = vld && (cnt == 0);
        e = vld && (cnt == CMAX);
        for (int i = 0; i < 2; i++) begin
            m_vld[i]  = 0;
            m_viol[i] = 0;
        end
        if (!rst) begin
            m_armed = 0;
            for (int i = 0; i < 2; i++) begin
                m_lat[i] = 0; m_sticky[i] = 0; m_cnt[i] = 0;
            end
        end else begin
            if (dis) begin
                m_armed = 0;
            end else if (s) begin
                m_armed = 1;
                m_st = cyc;
            end else if (e && m_armed) begin
                m_armed = 0;
                for (int i = 0; i < 2; i++) begin
                    m_lat[i]  = (cyc - m_st > m_max[i]) ? m_max[i] : cyc - m_st;
                    m_vld[i]  = 1;
                    m_viol[i] = (m_lat[i] >= LIMIT) ? 1 : 0;
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (m_viol[i] != 0) begin
                    m_sticky[i] = 1;
`ifdef WINDOW_LATENCY_MONITOR_VIOL_CNT_EN
                    if (m_cnt[i] < 255) m_cnt[i]++;
`endif
                end else if (clr) begin
                    m_sticky[i] = 0;
                end
            end
        end
    endtask

    task automatic step(input bit vld, input int cnt, input bit dis, input bit clr, input bit rst);
        count_vld_i = vld;
        count_i     = 3'(cnt);
        disable_i   = dis;
        clear_i     = clr;
        rst_n       = rst;
        @(posedge clk);
        #1;
        model(rst, vld, cnt, dis, clr);
        check_eq("lat_a",    32'(lat_a),     32'(m_lat[0]));
        check_eq("vld_a",    32'(lat_vld_a), 32'(m_vld[0]));
        check_eq("viol_a",   32'(viol_a),    32'(m_viol[0]));
        check_eq("sticky_a", 32'(sticky_a),  32'(m_sticky[0]));
        check_eq("cnt_a",    32'(cnt_a),     32'(m_cnt[0]));
        check_eq("lat_b",    32'(lat_b),     32'(m_lat[1]));
        check_eq("vld_b",    32'(lat_vld_b), 32'(m_vld[1]));
        check_eq("viol_b",   32'(viol_b),    32'(m_viol[1]));
        check_eq("sticky_b", 32'(sticky_b),  32'(m_sticky[1]));
        check_eq("cnt_b",    32'(cnt_b),     32'(m_cnt[1]));
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 1);
    endtask

    initial begin
        count_vld_i = 0; count_i = 0; disable_i = 0; clear_i = 0; rst_n = 0;
        #2;
        // Reset state
        check_eq("rst_lat",    32'(lat_a),    0);
        check_eq("rst_sticky", 32'(sticky_a), 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
        idle(2);

        // Counter advancing every cycle: latency 7, no violation
        for (int c = 0; c <= 7; c++) step(1, c, 0, 0, 1);
        check_eq("inc_lat", 32'(lat_a), 7);
        check_eq("inc_vld", 32'(lat_vld_a), 1);
        check_eq("inc_viol", 32'(viol_a), 0);
        idle(2);

        // Valid every 8th cycle: latency 56, violation
        for (int c = 0; c <= 7; c++) begin
            step(1, c, 0, 0, 1);
            if (c < 7) idle(7);
        end
        check_eq("slow_lat", 32'(lat_a), 56);
        check_eq("slow_viol", 32'(viol_a), 1);
        check_eq("slow_sticky", 32'(sticky_a), 1);
        idle(1);
        step(0, 0, 0, 1, 1);
        check_eq("clr_sticky", 32'(sticky_a), 0);

        // Disable mid-window aborts it; next window is measured
        for (int c = 0; c <= 7; c++) step(1, c, (c == 4), 0, 1);
        check_eq("dis_novld", 32'(lat_vld_a), 0);
        for (int c = 0; c <= 7; c++) step(1, c, 0, 0, 1);
        check_eq("dis_next_lat", 32'(lat_a), 7);

        // Disable beats a same-cycle start
        step(1, 0, 1, 0, 1);
        idle(3);
        step(1, 7, 0, 0, 1);
        check_eq("dis_start_novld", 32'(lat_vld_a), 0);

        // Restart: 0, 0 ten cycles later, 7 five cycles after that
        step(1, 0, 0, 0, 1);
        idle(9);
        step(1, 0, 0, 0, 1);
        idle(4);
        step(1, 7, 0, 0, 1);
        check_eq("restart_lat", 32'(lat_a), 5);

        // Long window: 6-bit timer saturates; clear coincides with violation
        step(1, 0, 0, 0, 1);
        idle(99);
        step(1, 7, 0, 1, 1);
        check_eq("sat_lat_b", 32'(lat_b), 63);
        check_eq("sat_viol_b", 32'(viol_b), 1);
        check_eq("sat_sticky_b", 32'(sticky_b), 1);
        check_eq("long_lat_a", 32'(lat_a), 100);

        // Reset mid-window at timer 30 discards the window
        step(1, 0, 0, 0, 1);
        idle(29);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        idle(1);
        step(1, 7, 0, 0, 1);
        check_eq("rstmid_vld", 32'(lat_vld_a), 0);
        check_eq("rstmid_lat", 32'(lat_a), 0);
        check_eq("rstmid_sticky", 32'(sticky_a), 0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            int r, c;
            bit v, d, k;
            r = $urandom_range(0, 99);
            if (r < 10)      c = 0;
            else if (r < 22) c = 7;
            else             c = $urandom_range(0, 7);
            v = ($urandom_range(0, 99) < 55);
            d = ($urandom_range(0, 59) == 0);
            k = ($urandom_range(0, 29) == 0);
            step(v, c, d, k, ($urandom_range(0, 499) != 0));
            if ($urandom_range(0, 99) == 0) idle($urandom_range(40, 110));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
